// File: rtl/nn_fixed_pkg.sv
// Shared Q8.8 fixed-point definitions for the XOR-network training stages:
// word size, saturating add/sub, controller states and the step schedule length.
package nn_fixed_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAC_BITS = 8;

  localparam logic signed [DATA_W-1:0] ONE     = 16'sh0100;
  localparam logic signed [DATA_W-1:0] MAX_VAL = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] MIN_VAL = 16'sh8000;

  localparam logic [4:0] STEP_LAST = 5'd16;

  typedef enum logic [1:0] {IDLE, CALC, UPDATE, DONE} state_t;

  function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) return s[DATA_W] ? MIN_VAL : MAX_VAL;
    return s[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_sub(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] s;
    s = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) return s[DATA_W] ? MIN_VAL : MAX_VAL;
    return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// Combinational Q8.8 multiply: full signed product, floor shift by the fraction
// width, saturation to the 16-bit signed range.
module fxp_mul_sat
  import nn_fixed_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] p
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] shifted;

  always_comb begin
    prod    = $signed(a) * $signed(b);
    shifted = prod >>> FRAC_BITS;
    if (shifted > 32'sd32767)       p = MAX_VAL;
    else if (shifted < -32'sd32768) p = MIN_VAL;
    else                            p = shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/backward_propagation.sv
// Backward-propagation stage of the 2-2-1 XOR network: one shared multiplier walks
// a 17-step schedule, then all weights/biases are updated at once.
// Optional macro GRAD_CLIP_EN clamps every update term to +/-CLIP_LIMIT.
module backward_propagation
  import nn_fixed_pkg::*;
#(
  parameter int unsigned       dataWidth  = DATA_W,
  parameter logic [DATA_W-1:0] CLIP_LIMIT = 16'h0080
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_bp,
  input  logic [dataWidth-1:0] x1,
  input  logic [dataWidth-1:0] x2,
  input  logic [dataWidth-1:0] h1,
  input  logic [dataWidth-1:0] h2,
  input  logic [dataWidth-1:0] y,
  input  logic [dataWidth-1:0] target,
  input  logic [dataWidth-1:0] lr,
  input  logic [dataWidth-1:0] w11,
  input  logic [dataWidth-1:0] w12,
  input  logic [dataWidth-1:0] w21,
  input  logic [dataWidth-1:0] w22,
  input  logic [dataWidth-1:0] w31,
  input  logic [dataWidth-1:0] w32,
  input  logic [dataWidth-1:0] b1,
  input  logic [dataWidth-1:0] b2,
  input  logic [dataWidth-1:0] b3,
  output logic [dataWidth-1:0] w11_new,
  output logic [dataWidth-1:0] w12_new,
  output logic [dataWidth-1:0] w21_new,
  output logic [dataWidth-1:0] w22_new,
  output logic [dataWidth-1:0] w31_new,
  output logic [dataWidth-1:0] w32_new,
  output logic [dataWidth-1:0] b1_new,
  output logic [dataWidth-1:0] b2_new,
  output logic [dataWidth-1:0] b3_new,
  output logic                 busy,
  output logic                 bp_valid
);

`ifdef GRAD_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  localparam logic [4:0] DRAIN = STEP_LAST + 5'd1;

  localparam int unsigned T_S3 = 0,  T_D3 = 1,  T_S1 = 2,  T_T1 = 3,  T_D1 = 4,  T_S2 = 5;
  localparam int unsigned T_T2 = 6,  T_D2 = 7,  T_LD3 = 8, T_LD1 = 9, T_LD2 = 10;
  localparam int unsigned T_U31 = 11, T_U32 = 12, T_U11 = 13, T_U12 = 14, T_U21 = 15, T_U22 = 16;

  state_t state_q, state_d;
  logic [4:0] step_q, step_d;

  logic signed [DATA_W-1:0] x1_s, x2_s, h1_s, h2_s, y_s, target_s, lr_s;
  logic signed [DATA_W-1:0] w11_s, w12_s, w21_s, w22_s, w31_s, w32_s, b1_s, b2_s, b3_s;

  logic signed [DATA_W-1:0] term [0:STEP_LAST];
  logic signed [DATA_W-1:0] op_a, op_b, prod_q;
  logic        [DATA_W-1:0] mul_p;

  function automatic logic signed [DATA_W-1:0] upd(input logic signed [DATA_W-1:0] t);
    if (CLIP_ON && t > $signed(CLIP_LIMIT))  return $signed(CLIP_LIMIT);
    if (CLIP_ON && t < -$signed(CLIP_LIMIT)) return -$signed(CLIP_LIMIT);
    return t;
  endfunction

  fxp_mul_sat u_mul (.a(op_a), .b(op_b), .p(mul_p));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // The product is registered, so step k's result lands in term[k] one cycle
  // later; the drain step retires the last product before UPDATE.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE:    if (enable_bp) begin state_d = CALC; step_d = '0; end
      CALC:    if (step_q == DRAIN) state_d = UPDATE; else step_d = step_q + 5'd1;
      UPDATE:  state_d = DONE;
      DONE:    if (!enable_bp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Steps 1, 4 and 7 consume the immediately preceding product straight from prod_q.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (step_q)
      5'd0:    begin op_a = y_s;                        op_b = sat_sub(ONE, y_s);  end
      5'd1:    begin op_a = sat_sub(y_s, target_s);     op_b = prod_q;             end
      5'd2:    begin op_a = h1_s;                       op_b = sat_sub(ONE, h1_s); end
      5'd3:    begin op_a = term[T_D3];                 op_b = w31_s;              end
      5'd4:    begin op_a = prod_q;                     op_b = term[T_S1];         end
      5'd5:    begin op_a = h2_s;                       op_b = sat_sub(ONE, h2_s); end
      5'd6:    begin op_a = term[T_D3];                 op_b = w32_s;              end
      5'd7:    begin op_a = prod_q;                     op_b = term[T_S2];         end
      5'd8:    begin op_a = lr_s;                       op_b = term[T_D3];         end
      5'd9:    begin op_a = lr_s;                       op_b = term[T_D1];         end
      5'd10:   begin op_a = lr_s;                       op_b = term[T_D2];         end
      5'd11:   begin op_a = term[T_LD3];                op_b = h1_s;               end
      5'd12:   begin op_a = term[T_LD3];                op_b = h2_s;               end
      5'd13:   begin op_a = term[T_LD1];                op_b = x1_s;               end
      5'd14:   begin op_a = term[T_LD1];                op_b = x2_s;               end
      5'd15:   begin op_a = term[T_LD2];                op_b = x1_s;               end
      5'd16:   begin op_a = term[T_LD2];                op_b = x2_s;               end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && enable_bp) begin
      x1_s  <= x1;  x2_s  <= x2;  h1_s  <= h1;  h2_s  <= h2;
      y_s   <= y;   target_s <= target;   lr_s <= lr;
      w11_s <= w11; w12_s <= w12; w21_s <= w21; w22_s <= w22;
      w31_s <= w31; w32_s <= w32; b1_s  <= b1;  b2_s  <= b2;  b3_s <= b3;
    end
    if (state_q == CALC) begin
      prod_q <= mul_p;
      if (step_q != 5'd0) term[step_q - 5'd1] <= prod_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w11_new <= '0; w12_new <= '0; w21_new <= '0; w22_new <= '0;
      w31_new <= '0; w32_new <= '0; b1_new  <= '0; b2_new  <= '0; b3_new <= '0;
      bp_valid <= 1'b0;
    end else begin
      case (state_q)
        UPDATE: begin
          w11_new  <= sat_sub(w11_s, upd(term[T_U11]));
          w12_new  <= sat_sub(w12_s, upd(term[T_U12]));
          w21_new  <= sat_sub(w21_s, upd(term[T_U21]));
          w22_new  <= sat_sub(w22_s, upd(term[T_U22]));
          w31_new  <= sat_sub(w31_s, upd(term[T_U31]));
          w32_new  <= sat_sub(w32_s, upd(term[T_U32]));
          b1_new   <= sat_sub(b1_s,  upd(term[T_LD1]));
          b2_new   <= sat_sub(b2_s,  upd(term[T_LD2]));
          b3_new   <= sat_sub(b3_s,  upd(term[T_LD3]));
          bp_valid <= 1'b1;
        end
        DONE:    if (!enable_bp) bp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy = (state_q == CALC) || (state_q == UPDATE);

endmodule
